iecdrv_sd_arb: RTL and testbench

- Arbitrates the per-drive SD sector requests of the multi-drive IEC block onto one host SD channel (one hps_io slot).
- Per-drive inputs: sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din. Per-drive output: sd_ack, routed back to each drive.
- Sits directly downstream of the multi-drive block in the clk_sys domain.
- Round-robin grant, one transfer in flight, ack-framed handshake.

---
 rtl/iecdrv_sd_arb.sv | 182 ++++++++++++++++++
 tb/tb_iecdrv_sd_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iecdrv_sd_arb.sv
// Round-robin arbiter for several drive SD request ports onto one host SD channel.
// Optional macro IECDRV_SD_ARB_TIMEOUT_EN adds a host-ack timeout with an err pulse.
module iecdrv_sd_arb #(
  parameter int          NDR     = 2,
  parameter logic [23:0] TIMEOUT = 24'd8000000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [31:0]     drv_sd_lba      [NDR],
  input  logic [5:0]      drv_sd_blk_cnt  [NDR],
  input  logic [NDR-1:0]  drv_sd_rd,
  input  logic [NDR-1:0]  drv_sd_wr,
  input  logic [7:0]      drv_sd_buff_din [NDR],
  output logic [NDR-1:0]  drv_sd_ack,
  output logic [31:0]     host_sd_lba,
  output logic [5:0]      host_sd_blk_cnt,
  output logic            host_sd_rd,
  output logic            host_sd_wr,
  input  logic            host_sd_ack,
  output logic [7:0]      host_sd_buff_din,
  output logic [1:0]      grant,
  output logic            busy,
  output logic            err
);

  localparam int GW = (NDR > 1) ? $clog2(NDR) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_r;
  logic [1:0]     grant_r;
  logic [1:0]     last_grant_r;
  logic [31:0]    lba_r;
  logic [5:0]     blk_r;
  logic           rd_r;
  logic           wr_r;
  logic           busy_r;
  logic [NDR-1:0] req_s;
  logic           pick_valid_s;
  logic [1:0]     pick_idx_s;
  logic [2:0]     scan_s;
  logic           active_s;

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
  logic [23:0]    to_cnt_r;
  logic           err_r;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign req_s            = drv_sd_rd | drv_sd_wr;
  assign active_s         = (state_r == ST_REQ) || (state_r == ST_XFER);
  assign host_sd_lba      = lba_r;
  assign host_sd_blk_cnt  = blk_r;
  assign host_sd_rd       = rd_r;
  assign host_sd_wr       = wr_r;
  assign grant            = grant_r;
  assign busy             = busy_r;
  assign host_sd_buff_din = drv_sd_buff_din[grant_r[GW-1:0]];

  // Round-robin scan: walk offsets downward so the port nearest last_grant+1 wins.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = 2'd0;
    scan_s       = 3'd0;
    for (int off = NDR; off >= 1; off--) begin
      scan_s = {1'b0, last_grant_r} + 3'(off);
      if (scan_s >= 3'(NDR)) begin
        scan_s = scan_s - 3'(NDR);
      end else begin
        scan_s = scan_s;
      end
      if (req_s[scan_s[GW-1:0]]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = scan_s[1:0];
      end else begin
        pick_valid_s = pick_valid_s;
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Ack goes straight back to the granted drive so it stays aligned with the broadcast buffer strobes.
  always_comb begin
    drv_sd_ack = {NDR{1'b0}};
    for (int i = 0; i < NDR; i++) begin
      if (grant_r == 2'(i)) begin
        drv_sd_ack[i] = host_sd_ack & active_s;
      end else begin
        drv_sd_ack[i] = 1'b0;
      end
    end
  end

  // Arbiter state machine with registered host request, address and status outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= 2'd0;
      last_grant_r <= 2'(NDR - 1);
      lba_r        <= 32'd0;
      blk_r        <= 6'd0;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      busy_r       <= 1'b0;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
      to_cnt_r     <= 24'd0;
      err_r        <= 1'b0;
`endif
    end else begin
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
      err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_r <= pick_idx_s;
            lba_r   <= drv_sd_lba[pick_idx_s[GW-1:0]];
            blk_r   <= drv_sd_blk_cnt[pick_idx_s[GW-1:0]];
            wr_r    <= drv_sd_wr[pick_idx_s[GW-1:0]];
            rd_r    <= ~drv_sd_wr[pick_idx_s[GW-1:0]];
            busy_r  <= 1'b1;
            state_r <= ST_REQ;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
            to_cnt_r <= 24'd0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (host_sd_ack) begin
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            state_r <= ST_XFER;
          end
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
          else if (to_cnt_r == TIMEOUT - 24'd1) begin
            rd_r         <= 1'b0;
            wr_r         <= 1'b0;
            err_r        <= 1'b1;
            last_grant_r <= grant_r;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + 24'd1;
          end
`else
          else begin
            state_r <= ST_REQ;
          end
`endif
        end
        ST_XFER: begin
          if (!host_sd_ack) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_DONE: begin
          last_grant_r <= grant_r;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          rd_r    <= 1'b0;
          wr_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iecdrv_sd_arb.sv
// Directed scoreboard bench for iecdrv_sd_arb (two drive ports).
module tb_iecdrv_sd_arb;

  localparam int NDR = 2;

  logic           clk_sys = 1'b0;
  logic           reset_n;
  logic [31:0]    drv_sd_lba      [NDR];
  logic [5:0]     drv_sd_blk_cnt  [NDR];
  logic [NDR-1:0] drv_sd_rd;
  logic [NDR-1:0] drv_sd_wr;
  logic [7:0]     drv_sd_buff_din [NDR];
  logic [NDR-1:0] drv_sd_ack;
  logic [31:0]    host_sd_lba;
  logic [5:0]     host_sd_blk_cnt;
  logic           host_sd_rd;
  logic           host_sd_wr;
  logic           host_sd_ack;
  logic [7:0]     host_sd_buff_din;
  logic [1:0]     grant;
  logic           busy;
  logic           err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic        rd;
    logic        wr;
  } exp_t;

  exp_t sbq[$];

  iecdrv_sd_arb #(.NDR(NDR), .TIMEOUT(24'd100)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .drv_sd_lba       (drv_sd_lba),
    .drv_sd_blk_cnt   (drv_sd_blk_cnt),
    .drv_sd_rd        (drv_sd_rd),
    .drv_sd_wr        (drv_sd_wr),
    .drv_sd_buff_din  (drv_sd_buff_din),
    .drv_sd_ack       (drv_sd_ack),
    .host_sd_lba      (host_sd_lba),
    .host_sd_blk_cnt  (host_sd_blk_cnt),
    .host_sd_rd       (host_sd_rd),
    .host_sd_wr       (host_sd_wr),
    .host_sd_ack      (host_sd_ack),
    .host_sd_buff_din (host_sd_buff_din),
    .grant            (grant),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic push(input logic [1:0] g, input logic [31:0] lba, input logic [5:0] blk,
                      input logic rd, input logic wr);
    exp_t e;
    e.g = g; e.lba = lba; e.blk = blk; e.rd = rd; e.wr = wr;
    sbq.push_back(e);
  endtask

  // Wait (bounded) for a host request, then pop the scoreboard and compare.
  task automatic expect_grant(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!(host_sd_rd || host_sd_wr) && n < 50) begin
      tick(1);
      n++;
    end
    chk({tag, "_req_seen"}, 64'(host_sd_rd | host_sd_wr), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_grant"}, 64'(grant), 64'(e.g));
      chk({tag, "_lba"},   64'(host_sd_lba), 64'(e.lba));
      chk({tag, "_blk"},   64'(host_sd_blk_cnt), 64'(e.blk));
      chk({tag, "_rd"},    64'(host_sd_rd), 64'(e.rd));
      chk({tag, "_wr"},    64'(host_sd_wr), 64'(e.wr));
    end
  endtask

  task automatic serve(input int n);
    host_sd_ack = 1'b1;
    tick(n);
    host_sd_ack = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    host_sd_ack = 1'b0;
    drv_sd_rd   = 2'b00;
    drv_sd_wr   = 2'b00;
    for (int i = 0; i < NDR; i++) begin
      drv_sd_lba[i]      = 32'd0;
      drv_sd_blk_cnt[i]  = 6'd0;
      drv_sd_buff_din[i] = 8'd0;
    end
    tick(2);
    chk("rst_rd",    64'(host_sd_rd), 64'd0);
    chk("rst_wr",    64'(host_sd_wr), 64'd0);
    chk("rst_lba",   64'(host_sd_lba), 64'd0);
    chk("rst_blk",   64'(host_sd_blk_cnt), 64'd0);
    chk("rst_ack",   64'(drv_sd_ack), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    reset_n = 1'b1;
    tick(8);

    // Single read from drive 0, one-cycle latency, long ack window.
    drv_sd_lba[0]     = 32'h0000_0165;
    drv_sd_blk_cnt[0] = 6'd0;
    drv_sd_rd         = 2'b01;
    push(2'd0, 32'h0000_0165, 6'd0, 1'b1, 1'b0);
    tick(1);
    chk("t1_latency_rd", 64'(host_sd_rd), 64'd1);
    expect_grant("t1");
    chk("t1_busy", 64'(busy), 64'd1);
    drv_sd_rd     = 2'b00;
    drv_sd_lba[0] = 32'hDEAD_BEEF;
    tick(3);
    chk("t1_hold_rd",  64'(host_sd_rd), 64'd1);
    chk("t1_hold_lba", 64'(host_sd_lba), 64'h165);
    host_sd_ack = 1'b1;
    #1;
    chk("t1_ack_same_cycle", 64'(drv_sd_ack), 64'b01);
    tick(1);
    chk("t1_rd_cleared", 64'(host_sd_rd), 64'd0);
    tick(254);
    chk("t1_ack_end", 64'(drv_sd_ack), 64'b01);
    host_sd_ack = 1'b0;
    #1;
    chk("t1_ack_drop", 64'(drv_sd_ack), 64'b00);
    tick(1);
    chk("t1_busy_done", 64'(busy), 64'd1);
    tick(1);
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // Round robin: both drives after reset, then drive 0 re-requests during drive 1.
    do_reset();
    drv_sd_lba[0] = 32'h0000_0100; drv_sd_blk_cnt[0] = 6'd1;
    drv_sd_lba[1] = 32'h0000_0200; drv_sd_blk_cnt[1] = 6'd2;
    push(2'd0, 32'h100, 6'd1, 1'b1, 1'b0);
    push(2'd1, 32'h200, 6'd2, 1'b1, 1'b0);
    drv_sd_rd = 2'b11;
    tick(1);
    expect_grant("rr0");
    drv_sd_rd = 2'b10;
    serve(3);
    expect_grant("rr1");
    drv_sd_rd = 2'b01;
    push(2'd0, 32'h100, 6'd1, 1'b1, 1'b0);
    serve(3);
    expect_grant("rr2");
    drv_sd_rd = 2'b00;
    serve(2);

    // Drive 1 asserts rd and wr together: write wins, its data is muxed out.
    drv_sd_lba[1]      = 32'h0000_0ABC;
    drv_sd_blk_cnt[1]  = 6'd5;
    drv_sd_buff_din[0] = 8'h3C;
    drv_sd_buff_din[1] = 8'hA5;
    push(2'd1, 32'hABC, 6'd5, 1'b0, 1'b1);
    drv_sd_rd = 2'b10;
    drv_sd_wr = 2'b10;
    tick(1);
    expect_grant("wr");
    drv_sd_rd = 2'b00;
    drv_sd_wr = 2'b00;
    host_sd_ack = 1'b1;
    #1;
    chk("wr_buff_din", 64'(host_sd_buff_din), 64'hA5);
    chk("wr_ack_drv1", 64'(drv_sd_ack), 64'b10);
    tick(4);
    host_sd_ack = 1'b0;
    tick(3);

    // Spurious ack while idle.
    host_sd_ack = 1'b1;
    #1;
    chk("spur_ack", 64'(drv_sd_ack), 64'b00);
    tick(2);
    chk("spur_busy",  64'(busy), 64'd0);
    chk("spur_rd",    64'(host_sd_rd | host_sd_wr), 64'd0);
    chk("spur_grant", 64'(grant), 64'd1);
    host_sd_ack = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of a transfer.
    drv_sd_lba[0] = 32'h0000_0777;
    push(2'd0, 32'h777, 6'd1, 1'b1, 1'b0);
    drv_sd_rd = 2'b01;
    tick(1);
    expect_grant("arst");
    drv_sd_rd = 2'b00;
    host_sd_ack = 1'b1;
    tick(1);
    chk("arst_pre_ack", 64'(drv_sd_ack), 64'b01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ack",  64'(drv_sd_ack), 64'b00);
    chk("arst_rdwr", 64'(host_sd_rd | host_sd_wr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    host_sd_ack = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_idle",  64'(busy), 64'd0);

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
    // Host never acks: timeout after 100 REQ cycles, then drive 1 is granted.
    drv_sd_lba[0] = 32'h0000_0010;
    drv_sd_lba[1] = 32'h0000_0020;
    push(2'd0, 32'h10, 6'd1, 1'b1, 1'b0);
    push(2'd1, 32'h20, 6'd2, 1'b1, 1'b0);
    drv_sd_rd = 2'b11;
    tick(1);
    expect_grant("to0");
    drv_sd_rd = 2'b10;
    n = 0;
    while (host_sd_rd && n < 200) begin
      tick(1);
      n++;
    end
    chk("to_cycles", 64'(n), 64'd100);
    chk("to_err_hi", 64'(err), 64'd1);
    chk("to_no_ack", 64'(drv_sd_ack), 64'b00);
    tick(1);
    chk("to_err_lo", 64'(err), 64'd0);
    expect_grant("to1");
    drv_sd_rd = 2'b00;
    serve(2);
`else
    chk("err_tied", 64'(err), 64'd0);
`endif

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
